i2c_byte_ctrl: RTL and testbench

Bit-level I2C master engine that sits directly upstream of the master FSM's 4-bit bit counter: it drives `count_inc`/`rst_count_2` into that counter and consumes its `count` output to index bits within a byte. It executes one command at a time (START, STOP, WRITE byte, READ byte), generates the open-drain SCL/SDA enables with a fixed quarter-bit timebase, and returns read data and the ACK status to the command issuer. No clock stretching and no arbitration detection.

---
 rtl/i2c_byte_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module : i2c_byte_ctrl
// Bit-level I2C master engine: START / STOP / WRITE byte / READ byte with a
// quarter-bit timebase, driving an external 4-bit bit counter.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_byte_ctrl #(
  parameter int QDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ack_out,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       rst_count_2,
  output logic       count_inc,
  input  logic [3:0] count
);

  localparam int            QW     = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QDIV - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_STOP  = 3'd2,
    S_BIT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    ph_q, ph_d;
  logic          busy_q, busy_d;
  logic          sda_hold_q, sda_hold_d;
  logic          is_read_q, is_read_d;
  logic [7:0]    wr_byte_q, wr_byte_d;
  logic          nack_q, nack_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          ack_q, ack_d;

  logic          accept;
  logic          q_last;
  logic          ph_end;
  logic          last_bit;
  logic [2:0]    bit_idx;
  logic          bit_sda;

  assign cmd_ready   = (state_q == S_IDLE);
  assign accept      = cmd_valid & cmd_ready & ~rst;
  assign q_last      = (qcnt_q == Q_LAST);
  assign ph_end      = q_last & (ph_q == 2'd3);
  // Counter values 9..15 are folded onto the ACK slot.
  assign last_bit    = count[3];
  assign bit_idx     = 3'd7 - count[2:0];

  assign done        = (state_q == S_DONE);
  assign count_inc   = (state_q == S_BIT) & ph_end;
  assign rst_count_2 = accept & cmd[1];
  assign rd_data     = rd_data_q;
  assign ack_out     = ack_q;
  assign busy        = busy_q;

  always_comb begin
    bit_sda = 1'b0;
    if (last_bit)       bit_sda = is_read_q & ~nack_q;
    else if (!is_read_q) bit_sda = ~wr_byte_q[bit_idx];
  end

  always_comb begin
    state_d    = state_q;
    qcnt_d     = '0;
    ph_d       = 2'd0;
    busy_d     = busy_q;
    sda_hold_d = sda_hold_q;
    is_read_d  = is_read_q;
    wr_byte_d  = wr_byte_q;
    nack_d     = nack_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    ack_d      = ack_q;
    // Between commands an owned bus keeps SCL low and SDA where it was left.
    scl_oe     = busy_q;
    sda_oe     = busy_q & sda_hold_q;

    if (state_q inside {S_START, S_STOP, S_BIT}) begin
      qcnt_d = q_last ? '0 : qcnt_q + QW'(1);
      ph_d   = q_last ? ph_q + 2'd1 : ph_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd == CMD_START) begin
            state_d = S_START;
          end else if (cmd == CMD_STOP) begin
            state_d = busy_q ? S_STOP : S_DONE;
          end else begin
            state_d   = S_BIT;
            is_read_d = cmd[0];
            wr_byte_d = wr_data;
            nack_d    = rd_nack;
          end
        end
      end
      S_START: begin
        scl_oe = (ph_q == 2'd0) ? busy_q : (ph_q == 2'd3);
        sda_oe = ph_q[1];
        if (ph_end) begin
          state_d = S_DONE;
          busy_d  = 1'b1;
        end
      end
      S_STOP: begin
        scl_oe = (ph_q == 2'd0);
        sda_oe = ~ph_q[1];
        if (ph_end) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end
      end
      S_BIT: begin
        scl_oe = ~ph_q[1];
        sda_oe = bit_sda;
        // SCL has been released for a full quarter when SDA is sampled.
        if (q_last && ph_q == 2'd2) begin
          if (is_read_q && !last_bit) shift_d = {shift_q[6:0], sda_in};
          if (!is_read_q && last_bit) ack_d = sda_in;
        end
        if (ph_end && last_bit) begin
          state_d = S_DONE;
          if (is_read_q) rd_data_d = shift_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q inside {S_START, S_STOP, S_BIT}) sda_hold_d = sda_oe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      ph_q       <= 2'd0;
      busy_q     <= 1'b0;
      sda_hold_q <= 1'b0;
      is_read_q  <= 1'b0;
      wr_byte_q  <= 8'd0;
      nack_q     <= 1'b0;
      shift_q    <= 8'd0;
      rd_data_q  <= 8'd0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      ph_q       <= ph_d;
      busy_q     <= busy_d;
      sda_hold_q <= sda_hold_d;
      is_read_q  <= is_read_d;
      wr_byte_q  <= wr_byte_d;
      nack_q     <= nack_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      ack_q      <= ack_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_ctrl.sv
`default_nettype none
// tb_i2c_byte_ctrl: directed and random command stream; expected results come
// from a byte-level model and are checked by a done-driven scoreboard monitor.
module tb_i2c_byte_ctrl;
  localparam int QDIV = 4;
  localparam int TMO  = 40 * QDIV + 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic       rd_nack = 1'b0;
  logic       cmd_ready, done, ack_out, busy, scl_oe, sda_oe;
  logic       rst_count_2, count_inc, sda_in;
  logic [7:0] rd_data;
  logic [3:0] count;

  i2c_byte_ctrl #(.QDIV(QDIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .wr_data(wr_data), .rd_nack(rd_nack), .done(done), .rd_data(rd_data),
    .ack_out(ack_out), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in), .rst_count_2(rst_count_2), .count_inc(count_inc), .count(count)
  );

  always #5 clk = ~clk;

  // External bit counter the engine drives.
  logic [3:0] cnt_q = 4'd0;
  always @(posedge clk) begin
    if (rst || rst_count_2) cnt_q <= 4'd0;
    else if (count_inc)     cnt_q <= cnt_q + 4'd1;
  end
  assign count = cnt_q;

  // Slave: drives read data MSB first, ACK/NACK on the 9th bit of a write.
  logic [1:0] cur_op = 2'b00;
  logic [7:0] slv_byte = 8'h00;
  logic       slv_ack = 1'b1;
  logic       slv_out;
  always_comb begin
    slv_out = 1'b1;
    if (cur_op == 2'b11 && cnt_q < 4'd8)       slv_out = slv_byte[3'(4'd7 - cnt_q)];
    else if (cur_op == 2'b10 && cnt_q >= 4'd8) slv_out = slv_ack;
  end
  assign sda_in = ~sda_oe & slv_out;

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0] op;
    int         lat;
    logic [7:0] rd;
    logic       ack;
    logic       busy;
    logic       sda_idle;
    logic [8:0] pat9;
    logic [7:0] ph_pat;
    logic       chk_ph;
  } exp_t;
  exp_t sb[$];

  // Byte-level reference state.
  logic       m_busy = 1'b0, m_sda = 1'b0, m_ack = 1'b0;
  logic [7:0] m_rd = 8'h00;

  task automatic model_reset();
    m_busy = 1'b0; m_sda = 1'b0; m_ack = 1'b0; m_rd = 8'h00;
  endtask

  // Monitor: collects bus activity per command, compares on done.
  int         negcnt = 0, acc_neg = 0, inc_cnt = 0, rc_cnt = 0, falls = 0;
  logic       inflight = 1'b0, prev_scl = 1'b0, ph_bad = 1'b0;
  logic [1:0] op_m = 2'b00;
  logic [8:0] pat9 = 9'd0;
  logic [7:0] ph_pat = 8'd0;

  always @(negedge clk) begin
    int   k;
    exp_t e;
    negcnt++;
    if (rst) begin
      sb.delete();
      inflight = 1'b0;
    end else begin
      if (done) begin
        if (!inflight || sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", negcnt - acc_neg, e.lat);
          chk("rd_data", rd_data, e.rd);
          chk("ack_out", ack_out, e.ack);
          chk("busy", busy, e.busy);
          chk("idle_scl", scl_oe, e.busy);
          chk("idle_sda", sda_oe, e.sda_idle);
          if (e.op[1]) begin
            chk("scl_falls", falls, 9);
            chk("sda_bits", pat9, e.pat9);
            chk("count_inc_n", inc_cnt, 9);
            chk("rst_count_n", rc_cnt, 1);
          end else begin
            chk("count_inc_n", inc_cnt, 0);
            chk("rst_count_n", rc_cnt, 0);
            if (e.chk_ph) begin
              chk("phase_wave", ph_pat, e.ph_pat);
              chk("phase_steady", ph_bad, 0);
            end
          end
        end
        inflight = 1'b0;
      end else if (inflight) begin
        if (count_inc)   inc_cnt++;
        if (rst_count_2) rc_cnt++;
        k = negcnt - acc_neg - 1;
        if (!op_m[1]) begin
          if (k < 4 * QDIV) begin
            if (k % QDIV == 0) ph_pat[2*(k/QDIV) +: 2] = {scl_oe, sda_oe};
            else if (ph_pat[2*(k/QDIV) +: 2] != {scl_oe, sda_oe}) ph_bad = 1'b1;
          end
        end else if (prev_scl && !scl_oe) begin
          pat9 = {pat9[7:0], sda_oe};
          falls++;
        end
        prev_scl = scl_oe;
      end
      if (cmd_valid && cmd_ready) begin
        inflight = 1'b1; acc_neg = negcnt; op_m = cmd;
        inc_cnt = 0; rc_cnt = rst_count_2 ? 1 : 0; falls = 0;
        pat9 = 9'd0; ph_pat = 8'd0; ph_bad = 1'b0; prev_scl = scl_oe;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                       input logic [7:0] sbyte, input logic sack);
    exp_t e;
    int   t;
    e.op = op; e.pat9 = 9'd0; e.ph_pat = 8'd0; e.chk_ph = 1'b0;
    case (op)
      2'b00: begin
        e.lat = 4 * QDIV + 1;
        e.ph_pat = {2'b11, 2'b01, 2'b00, m_busy, 1'b0};
        e.chk_ph = 1'b1;
        m_busy = 1'b1; m_sda = 1'b1;
      end
      2'b01: begin
        if (m_busy) begin
          e.lat = 4 * QDIV + 1;
          e.ph_pat = {2'b00, 2'b00, 2'b01, 2'b11};
          e.chk_ph = 1'b1;
        end else begin
          e.lat = 1;
        end
        m_busy = 1'b0; m_sda = 1'b0;
      end
      2'b10: begin
        e.lat = 36 * QDIV + 1;
        for (int i = 0; i < 8; i++) e.pat9[8-i] = ~wd[7-i];
        m_ack = sack; m_sda = 1'b0;
      end
      default: begin
        e.lat = 36 * QDIV + 1;
        e.pat9 = {8'h00, ~nk};
        m_rd = sbyte; m_sda = ~nk;
      end
    endcase
    e.rd = m_rd; e.ack = m_ack; e.busy = m_busy; e.sda_idle = m_busy & m_sda;
    sb.push_back(e);
    cur_op = op; slv_byte = sbyte; slv_ack = sack;
    cmd = op; wr_data = wd; rd_nack = nk; cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = 2'($urandom); wr_data = 8'($urandom); rd_nack = 1'($urandom);
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < TMO);
    if (!done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_count_inc", count_inc, 0);
    chk("rst_rst_count_2", rst_count_2, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(2'b00, 8'h00, 1'b0, 8'h00, 1'b1);   // START
    issue(2'b01, 8'h00, 1'b0, 8'h00, 1'b1);   // STOP
    issue(2'b01, 8'h00, 1'b0, 8'h00, 1'b1);   // STOP on idle bus
    issue(2'b00, 8'h00, 1'b0, 8'h00, 1'b1);   // START
    issue(2'b10, 8'hA5, 1'b0, 8'h00, 1'b0);   // WRITE 0xA5, slave ACKs
    issue(2'b00, 8'h00, 1'b0, 8'h00, 1'b1);   // repeated START
    issue(2'b11, 8'h00, 1'b1, 8'h3C, 1'b1);   // READ 0x3C with NACK
    issue(2'b10, 8'h00, 1'b0, 8'h00, 1'b1);   // WRITE 0x00, slave NACKs
    issue(2'b01, 8'h00, 1'b0, 8'h00, 1'b1);   // STOP

    // Reset in the middle of a write, with a START held on cmd during reset.
    issue(2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
    cur_op = 2'b10; slv_ack = 1'b0;
    cmd = 2'b10; wr_data = 8'h96; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (cnt_q != 4'd4 && t < TMO);
    chk("reach_bit4", cnt_q, 4);
    @(posedge clk); #1;
    rst = 1'b1; cmd = 2'b00; cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_scl", scl_oe, 0);
    chk("midrst_sda", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_ready", cmd_ready, 1);
    @(posedge clk); #1;
    issue(2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
    issue(2'b01, 8'h00, 1'b0, 8'h00, 1'b1);

    for (int n = 0; n < 25; n++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
            8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    issue(2'b01, 8'h00, 1'b0, 8'h00, 1'b1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
